// File: rtl/dmux_stream.sv
// dmux_stream
//   Registered 1-to-CHANNELS stream demultiplexer. It routes one valid/ready
//   input beat per cycle to the output channel named by in_sel. Each output
//   channel has a one-entry holding register, so a stalled consumer only
//   blocks beats that are heading for its own channel.
//
// Parameters
//   WIDTH     payload width in bits (>= 1)
//   CHANNELS  number of output channels (2..16)
//   SEL_W     select width; CHANNELS must not exceed 2**SEL_W
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; wins over any beat in flight
//   in_data    input payload
//   in_sel     destination channel for the current beat
//   in_valid   producer offers a beat
//   in_ready   block accepts a beat this cycle (combinational, independent
//              of in_valid)
//   out_data   channel i payload at [i*WIDTH +: WIDTH]
//   out_valid  per-channel holding register full
//   out_ready  per-channel consumer accepts
//   err_drop   one-cycle pulse after a beat with out-of-range in_sel was
//              consumed and discarded
//   beat_cnt   per-channel 16-bit accepted-beat counters at [i*16 +: 16]
//
// Build option
//   DMUX_STREAM_STATS_EN  when defined, beat_cnt counts loads per channel
//                         (wrapping at 16 bits); when undefined, beat_cnt is
//                         tied to zero and no counters exist.

module dmux_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err_drop,
  output logic [CHANNELS*16-1:0]    beat_cnt
);

  logic [CHANNELS-1:0]       sel_hot;
  logic                      sel_ok;
  logic                      accept;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS-1:0]       drain;
  logic [CHANNELS*WIDTH-1:0] data_q;
  logic [CHANNELS-1:0]       valid_q;
  logic                      err_q;

  // One-hot decode of the select. A select that matches no channel leaves
  // sel_hot all-zero, which is how an out-of-range beat is recognised without
  // ever indexing past the last channel.
  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_hot[i] = (in_sel == SEL_W'(i));
    end
  end

  assign sel_ok = |sel_hot;

  // A channel can take a beat when it is empty or being drained in the same
  // cycle. Out-of-range beats are always taken so they can be discarded.
  assign in_ready = !sel_ok || |(sel_hot & (~valid_q | out_ready));
  assign accept   = in_valid && in_ready;
  assign load     = sel_hot & {CHANNELS{accept}};
  assign drain    = valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load[i]) begin
          // Load wins over drain: a simultaneous drain hands off the old beat
          // while the new one takes its place, keeping full throughput.
          data_q[i*WIDTH +: WIDTH] <= in_data;
          valid_q[i]               <= 1'b1;
        end else if (drain[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      err_q <= accept && !sel_ok;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign err_drop  = err_q;

`ifdef DMUX_STREAM_STATS_EN
  logic [CHANNELS*16-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load[i]) begin
          cnt_q[i*16 +: 16] <= cnt_q[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign beat_cnt = cnt_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Parametrised, registered successor to the 1-bit combinational demultiplexer.
- Routes a WIDTH-bit data stream from one valid/ready input to one of CHANNELS valid/ready outputs, selected per beat by in_sel.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Sits between a producer (ALU/memory-side datapath) and multiple independent consumers.

Parameters:
- WIDTH, 16, data width in bits (>=1).
- CHANNELS, 4, number of output channels (2..16).
- SEL_W, 2, select width; CHANNELS <= 2**SEL_W is required.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  SEL_W  destination channel for the current beat.
- in_valid  input  1  producer offers a beat.
- in_ready  output  1  block accepts a beat this cycle (combinational).
- out_data  output  CHANNELS*WIDTH  channel i payload at [i*WIDTH +: WIDTH].
- out_valid  output  CHANNELS  per-channel holding register full.
- out_ready  input  CHANNELS  per-channel consumer accepts.
- err_drop  output  1  one-cycle registered pulse: a beat with out-of-range in_sel was discarded.
- beat_cnt  output  CHANNELS*16  per-channel accepted-beat counters; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at a rising edge): out_valid=0, out_data=0, err_drop=0, beat_cnt=0. Takes priority over all other activity, including a beat in flight. A held beat is lost, not delivered.
- Define s=in_sel.
- If s < CHANNELS: in_ready = !out_valid[s] || out_ready[s].
- If s >= CHANNELS: in_ready = 1.
- in_ready does not depend on in_valid.
- Accept = in_valid && in_ready. Latency from accept to out_valid[s]=1 is 1 cycle.
- Per channel i, each cycle:
  - load = accept && s==i.
  - If load: out_data[i] <= in_data, out_valid[i] <= 1. Simultaneous out_ready[i] drains the old beat and loads the new one, giving full throughput.
  - Else if out_valid[i] && out_ready[i]: out_valid[i] <= 0. out_data[i] holds its last value.
  - Else: hold.
- Channels not selected are never disturbed. out_ready on an empty channel has no effect.
- Out-of-range select (s >= CHANNELS, possible only when CHANNELS < 2**SEL_W):
  - The beat is consumed and discarded.
  - err_drop = 1 on the following cycle only.
  - No channel changes.
- in_valid=0: no load, err_drop=0 next cycle. Draining continues normally.
- Back-pressure: while channel s is full and not draining, in_ready=0. The producer must hold in_data/in_sel/in_valid stable until accepted. The block does not check this.
- One beat per cycle maximum; in-order delivery within each channel.

Optional Feature:
- Macro: DMUX_STREAM_STATS_EN.
- Defined: beat_cnt[i*16 +: 16] increments by 1 on every load into channel i. Wraps 0xFFFF -> 0x0000. Dropped beats are not counted. Synchronous clear on reset.
- Undefined: beat_cnt is tied to all-zero and no counter registers are built. All other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_n=0 2 cycles with in_valid=1 -> out_valid=0000, out_data=0, err_drop=0, beat_cnt=0. After rst_n=1, in_ready=1 for every in_sel.
- Single routing: in_data=0xA5A5, in_sel=2, in_valid=1 one cycle, out_ready=0000 -> next cycle out_valid=0100, channel 2 data=0xA5A5, other channels 0. A second beat to sel=2 sees in_ready=0 until out_ready[2]=1.
- Full throughput: out_ready=1111, stream 0x0001..0x0008 with sel cycling 0,1,2,3 -> in_ready stays 1. Each channel shows its beats in order one cycle after accept; no bubbles.
- Isolation: channel 1 full with out_ready[1]=0, then beat 0x1234 to sel=3 -> accepted (in_ready=1); channel 1 data and valid unchanged.
- Out-of-range drop: CHANNELS=3, SEL_W=2, in_sel=3, in_data=0xBEEF -> in_ready=1, err_drop=1 for exactly one cycle, out_valid unchanged, beat_cnt unchanged.
- Stats wrap (DMUX_STREAM_STATS_EN defined): 65537 beats to sel=0 with out_ready[0]=1 -> channel 0 count=0x0001, others 0. Then reset mid-stream -> all counters and out_valid return to 0.
